// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and the write-source encoding for the register-file write-back path.
// src_t values are chosen so they can drive write_data_sel directly.
package regfile_wb_arbiter_pkg;

  localparam int REG_AW = 3;
  localparam int REG_DW = 32;
  localparam int NREGS  = 8;

  typedef enum logic {
    SRC_ID  = 1'b0,
    SRC_ALU = 1'b1
  } src_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter for the write port.
// last_grant remembers the most recent winner; on contention the other side wins.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_id,
  output logic gnt_alu,
  output logic gnt_id,
  output src_t last_grant
);

  always_comb begin
    gnt_alu = req_alu && (!req_id || (last_grant == SRC_ID));
    gnt_id  = req_id  && (!req_alu || (last_grant == SRC_ALU));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= SRC_ID;
    end else if (gnt_alu) begin
      last_grant <= SRC_ALU;
    end else if (gnt_id) begin
      last_grant <= SRC_ID;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 8 x 32-bit register file.
// Handshake: a transfer happens in any cycle where valid && ready; requesters hold addr/data while valid && !ready.
module regfile_wb_arbiter #(
  parameter int NREGS = regfile_wb_arbiter_pkg::NREGS,
  parameter int DW    = regfile_wb_arbiter_pkg::REG_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [$clog2(NREGS)-1:0] alu_addr,
  input  logic [DW-1:0]            alu_data,
  input  logic                     id_valid,
  output logic                     id_ready,
  input  logic [$clog2(NREGS)-1:0] id_addr,
  input  logic [DW-1:0]            id_data,
  input  logic                     claim_valid,
  output logic                     claim_ready,
  input  logic [$clog2(NREGS)-1:0] claim_addr,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic                     hazard,
  input  logic                     flush,
  output logic [$clog2(NREGS)-1:0] write_addr,
  output logic [DW-1:0]            write_value_alu,
  output logic [DW-1:0]            write_value_id,
  output logic                     write_data_sel,
  output logic                     write_enable,
  output logic [NREGS-1:0]         busy
);

  import regfile_wb_arbiter_pkg::*;

  logic       req_alu;
  logic       req_id;
  logic       gnt_alu;
  logic       gnt_id;
  src_t       last_grant;
  src_t       write_src;
  logic       claim_fire;
  logic [NREGS-1:0] busy_next;

  // Reset and flush both close every port, so nothing is accepted that would be dropped.
  assign req_alu = alu_valid && !flush && reset;
  assign req_id  = id_valid  && !flush && reset;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_alu    (req_alu),
    .req_id     (req_id),
    .gnt_alu    (gnt_alu),
    .gnt_id     (gnt_id),
    .last_grant (last_grant)
  );

  assign alu_ready      = gnt_alu;
  assign id_ready       = gnt_id;
  assign write_data_sel = write_src;

  assign claim_ready = !busy[claim_addr] && !flush && reset;
  assign claim_fire  = claim_valid && claim_ready;
  assign hazard      = busy[rs1_addr] | busy[rs2_addr];

  // A claim can only be accepted for a non-busy register, so letting the set win is safe.
  always_comb begin
    busy_next = busy;
    if (write_enable) begin
      busy_next[write_addr] = 1'b0;
    end
    if (claim_fire) begin
      busy_next[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Only the value register of the winning source loads; the other keeps its old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable    <= 1'b0;
      write_addr      <= '0;
      write_src       <= SRC_ID;
      write_value_alu <= '0;
      write_value_id  <= '0;
    end else if (flush) begin
      write_enable    <= 1'b0;
    end else if (gnt_alu) begin
      write_enable    <= 1'b1;
      write_addr      <= alu_addr;
      write_src       <= SRC_ALU;
      write_value_alu <= alu_data;
    end else if (gnt_id) begin
      write_enable    <= 1'b1;
      write_addr      <= id_addr;
      write_src       <= SRC_ID;
      write_value_id  <= id_data;
    end else begin
      write_enable    <= 1'b0;
    end
  end

  a_one_ready : assert property (@(posedge clk) disable iff (!reset)
    !(alu_ready && id_ready));

  a_rr_fair : assert property (@(posedge clk) disable iff (!reset)
    (req_alu && req_id) |-> (gnt_alu == (last_grant == SRC_ID)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: handshakes push expected writes to a queue,
// and every observed write_enable pops and compares one entry.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [2:0]  alu_addr;
  logic [31:0] alu_data;
  logic        id_valid, id_ready;
  logic [2:0]  id_addr;
  logic [31:0] id_data;
  logic        claim_valid, claim_ready;
  logic [2:0]  claim_addr, rs1_addr, rs2_addr;
  logic        hazard, flush;
  logic [2:0]  write_addr;
  logic [31:0] write_value_alu, write_value_id;
  logic        write_data_sel, write_enable;
  logic [7:0]  busy;

  logic [35:0] exp_q[$];
  logic [31:0] mdl_alu, mdl_id;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_addr(id_addr), .id_data(id_data),
    .claim_valid(claim_valid), .claim_ready(claim_ready), .claim_addr(claim_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard), .flush(flush),
    .write_addr(write_addr), .write_value_alu(write_value_alu), .write_value_id(write_value_id),
    .write_data_sel(write_data_sel), .write_enable(write_enable), .busy(busy)
  );

  task automatic idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    id_valid = 1'b0; id_addr = '0; id_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    rs1_addr = '0; rs2_addr = '0; flush = 1'b0;
  endtask

  // Record handshakes of the current cycle, advance one edge, then score any write.
  task automatic step();
    logic [35:0] exp;
    if (alu_valid && alu_ready) exp_q.push_back({1'b1, alu_addr, alu_data});
    if (id_valid && id_ready) exp_q.push_back({1'b0, id_addr, id_data});
    @(posedge clk);
    #1;
    if (write_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: write_enable=1 addr=%0d sel=%0d, no write expected", write_addr, write_data_sel);
      end else begin
        exp = exp_q.pop_front();
        if (exp[35]) mdl_alu = exp[31:0];
        else mdl_id = exp[31:0];
        if ({write_data_sel, write_addr, write_value_alu, write_value_id} !== {exp[35], exp[34:32], mdl_alu, mdl_id}) begin
          errors++;
          $display("FAIL wb_data: got sel=%0d addr=%0d alu=%h id=%h, expected sel=%0d addr=%0d alu=%h id=%h",
                   write_data_sel, write_addr, write_value_alu, write_value_id, exp[35], exp[34:32], mdl_alu, mdl_id);
        end
      end
    end
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    exp_q.delete();
    mdl_alu = '0;
    mdl_id = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    exp_q.delete();
    mdl_alu = '0;
    mdl_id = '0;
    @(posedge clk);
    #1;
    checks++;
    if ({alu_ready, id_ready, claim_ready, hazard, write_addr, write_value_alu, write_value_id,
         write_data_sel, write_enable, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%0d addr=%0d alu=%h id=%h sel=%0d busy=%h rdy=%0d%0d%0d hz=%0d, expected all 0",
               write_enable, write_addr, write_value_alu, write_value_id, write_data_sel, busy,
               alu_ready, id_ready, claim_ready, hazard);
    end
    reset = 1'b1;
    #1;
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: alu_ready=%0d, expected 1", alu_ready);
    end
    step();
    alu_valid = 1'b0;
    checks++;
    if (write_enable !== 1'b1) begin
      errors++;
      $display("FAIL first_write_enable: write_enable=%0d, expected 1", write_enable);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic exp_alu;
    apply_reset();
    alu_valid = 1'b1; alu_addr = 3'd1; alu_data = $urandom;
    id_valid = 1'b1; id_addr = 3'd2; id_data = $urandom;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_alu = (i % 2 == 0);
      checks++;
      if ({alu_ready, id_ready} !== {exp_alu, !exp_alu}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: alu_ready=%0d id_ready=%0d, expected %0d %0d",
                 i, alu_ready, id_ready, exp_alu, !exp_alu);
      end
      step();
      if (exp_alu) alu_data = $urandom;
      else id_data = $urandom;
      #1;
    end
    idle();
    #1;
    step();
  endtask

  task automatic test_claim_hazard();
    apply_reset();
    claim_valid = 1'b1; claim_addr = 3'd5; rs1_addr = 3'd5; rs2_addr = 3'd0;
    #1;
    checks++;
    if ({claim_ready, hazard} !== 2'b10) begin
      errors++;
      $display("FAIL claim_same_cycle: claim_ready=%0d hazard=%0d, expected 1 0", claim_ready, hazard);
    end
    step();
    claim_valid = 1'b0;
    #1;
    checks++;
    if ({hazard, busy} !== {1'b1, 8'h20}) begin
      errors++;
      $display("FAIL claim_busy: hazard=%0d busy=%h, expected 1 20", hazard, busy);
    end
    id_valid = 1'b1; id_addr = 3'd5; id_data = $urandom;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL id_grant: id_ready=%0d, expected 1", id_ready);
    end
    step();
    id_valid = 1'b0;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL raw_n1: hazard=%0d, expected 1", hazard);
    end
    step();
    checks++;
    if ({hazard, busy} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL raw_n2: hazard=%0d busy=%h, expected 0 00", hazard, busy);
    end
  endtask

  task automatic test_waw_stall();
    apply_reset();
    claim_valid = 1'b1; claim_addr = 3'd4;
    #1;
    step();
    claim_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 3'd4; alu_data = $urandom;
    #1;
    step();
    alu_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 3'd4;
    #1;
    checks++;
    if ({claim_ready, write_enable, write_addr} !== {1'b0, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL waw_stall: claim_ready=%0d we=%0d addr=%0d, expected 0 1 4", claim_ready, write_enable, write_addr);
    end
    step();
    checks++;
    if ({claim_ready, busy} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL waw_release: claim_ready=%0d busy=%h, expected 1 00", claim_ready, busy);
    end
    step();
    claim_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 8'h10) begin
      errors++;
      $display("FAIL waw_reclaim: busy=%h, expected 10", busy);
    end
  endtask

  task automatic test_flush();
    logic [2:0] regs [3];
    regs = '{3'd1, 3'd3, 3'd5};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      claim_valid = 1'b1; claim_addr = regs[i];
      #1;
      step();
    end
    claim_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 3'd0; alu_data = $urandom;
    #1;
    step();
    alu_valid = 1'b0;
    checks++;
    if ({busy, write_enable} !== {8'h2A, 1'b1}) begin
      errors++;
      $display("FAIL flush_setup: busy=%h we=%0d, expected 2a 1", busy, write_enable);
    end
    flush = 1'b1;
    alu_valid = 1'b1; id_valid = 1'b1; claim_valid = 1'b1; claim_addr = 3'd0;
    #1;
    checks++;
    if ({alu_ready, id_ready, claim_ready} !== 3'b000) begin
      errors++;
      $display("FAIL flush_readys: alu=%0d id=%0d claim=%0d, expected 0 0 0", alu_ready, id_ready, claim_ready);
    end
    step();
    idle();
    #1;
    checks++;
    if ({busy, write_enable} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL flush_clear: busy=%h we=%0d, expected 00 0", busy, write_enable);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    claim_valid = 1'b1; claim_addr = 3'd2;
    #1;
    step();
    claim_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 3'd6; alu_data = $urandom;
    #1;
    step();
    alu_valid = 1'b0;
    checks++;
    if ({write_enable, busy} !== {1'b1, 8'h04}) begin
      errors++;
      $display("FAIL midreset_setup: we=%0d busy=%h, expected 1 04", write_enable, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({write_enable, busy} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midreset_drop: we=%0d busy=%h, expected 0 00", write_enable, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    alu_valid = 1'b1; alu_addr = 3'd7; alu_data = $urandom;
    id_valid = 1'b1; id_addr = 3'd1; id_data = $urandom;
    #1;
    checks++;
    if ({alu_ready, id_ready} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_grant: alu_ready=%0d id_ready=%0d, expected 1 0", alu_ready, id_ready);
    end
    step();
    alu_valid = 1'b0;
    #1;
    step();
    idle();
    #1;
    step();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    mdl_alu = '0;
    mdl_id = '0;
    test_reset();
    test_round_robin();
    test_claim_hazard();
    test_waw_stall();
    test_flush();
    test_reset_midstream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_drain: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
